// File: rtl/decoder_row_scanner_pkg.sv
// Shared types and helpers for the row-scan decoder: scan states and row-index clamping.
package decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } scan_state_t;

    // Manual selections past the last scanned row pin to the last row.
    function automatic int clamp_row(input int v, input int rows);
        return (v >= rows) ? rows - 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/decoder_row_scanner_if.sv
// Control and row-drive bundle between the frame logic / row pins and the scanner.
interface decoder_row_scanner_if #(
    parameter int N = 3
);
    logic              ena;
    logic              mode;
    logic [N-1:0]      sel;
    logic [2**N-1:0]   out;
    logic [N-1:0]      idx;
    logic              row_start;
    logic              frame_done;

    modport master (
        output ena, mode, sel,
        input  out, idx, row_start, frame_done
    );

    modport slave (
        input  ena, mode, sel,
        output out, idx, row_start, frame_done
    );
endinterface

// File: rtl/decoder_row_scanner_onehot.sv
// Combinational N-to-2^N one-hot decoder with an enable; all bits low when disabled.
module decoder_n_to_onehot #(
    parameter int N = 3
) (
    input  logic              ena,
    input  logic [N-1:0]      in,
    output logic [2**N-1:0]   out
);
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_bit
        assign out[gi] = ena && (in == N'(gi));
    end
endmodule

// File: rtl/decoder_row_scanner.sv
// Registered one-hot row driver with auto/manual row-scan sequencing and inter-row blanking.
module decoder_row_scanner
    import decoder_pkg::*;
#(
    parameter int N              = 3,
    parameter int ROWS           = 8,
    parameter int DWELL          = 1000,
    parameter int BLANK          = 4,
    parameter int OUT_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_row_scanner_if.slave  bus
);
    localparam int OUT_W = 2**N;
    localparam int CNT_W = $clog2(max3(DWELL, BLANK, 2));
    localparam logic [OUT_W-1:0] OFF_PATTERN =
        (OUT_ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [N-1:0]     LAST_ROW   = N'(ROWS - 1);

    scan_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [N-1:0]      r_idx;
    logic [OUT_W-1:0]  r_out;
    logic              r_row_start;
    logic              r_frame_done;

    scan_state_t       w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [N-1:0]      w_idx_next;
    logic              w_row_start_next;
    logic              w_frame_done_next;
    logic [N-1:0]      w_manual_idx;
    logic [N-1:0]      w_adv_idx;
    logic              w_adv_frame;
    logic              w_drive;
    logic [OUT_W-1:0]  w_onehot;

    // Next-row rule, applied only when a new row visit begins.
    always_comb begin
        w_manual_idx = N'(clamp_row(int'(bus.sel), ROWS));
        w_adv_frame  = 1'b0;
        if (bus.mode) begin
            w_adv_idx = w_manual_idx;
        end else if (r_idx == LAST_ROW) begin
            w_adv_idx   = '0;
            w_adv_frame = 1'b1;
        end else begin
            w_adv_idx = r_idx + N'(1);
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt + CNT_W'(1);
        w_idx_next        = r_idx;
        w_row_start_next  = 1'b0;
        w_frame_done_next = 1'b0;
        if (!bus.ena) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next     = S_ACTIVE;
                    w_cnt_next       = '0;
                    w_idx_next       = bus.mode ? w_manual_idx : '0;
                    w_row_start_next = 1'b1;
                end
                S_ACTIVE: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_cnt_next = '0;
                        if (BLANK > 0) begin
                            w_state_next = S_BLANK;
                        end else begin
                            w_idx_next        = w_adv_idx;
                            w_row_start_next  = 1'b1;
                            w_frame_done_next = w_adv_frame;
                        end
                    end
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_next      = S_ACTIVE;
                        w_cnt_next        = '0;
                        w_idx_next        = w_adv_idx;
                        w_row_start_next  = 1'b1;
                        w_frame_done_next = w_adv_frame;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    assign w_drive = (w_state_next == S_ACTIVE);

    // Decode from the next-state index so out lines up with idx in the same cycle.
    decoder_n_to_onehot #(.N(N)) u_dec (
        .ena (w_drive),
        .in  (w_idx_next),
        .out (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_out        <= OFF_PATTERN;
            r_row_start  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_out        <= w_onehot ^ OFF_PATTERN;
            r_row_start  <= w_row_start_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign bus.out        = r_out;
    assign bus.idx        = r_idx;
    assign bus.row_start  = r_row_start;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_decoder_row_scanner.sv
// Scoreboard bench: four scanner configurations, row visits checked as they are presented.
module tb_decoder_row_scanner;
    localparam int NI = 4;
    // 0: base config, 1: ROWS=6 manual, 2: active-low, 3: ROWS=1 BLANK=0
    localparam int P_ROWS  [NI] = '{8, 6, 8, 1};
    localparam int P_BLANK [NI] = '{2, 2, 2, 0};
    localparam int P_AL    [NI] = '{0, 0, 1, 0};
    localparam int DW = 4;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] out;
        logic       fd;
        int         gap;
    } exp_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst_n = '0;
    int            checks = 0;
    int            errors = 0;
    exp_t          exp_q [NI][$];

    decoder_row_scanner_if #(.N(3)) bus [NI] ();

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        decoder_row_scanner #(
            .N(3), .ROWS(P_ROWS[gi]), .DWELL(DW),
            .BLANK(P_BLANK[gi]), .OUT_ACTIVE_LOW(P_AL[gi])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n[gi]),
            .bus   (bus[gi])
        );
    end

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h", k, name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [2:0] idx, input logic [7:0] o, input logic fd, input int gap);
        exp_t e;
        e.idx = idx; e.out = o; e.fd = fd; e.gap = gap;
        exp_q[k].push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: each row_start pops one expected visit; gap and lit cycles verify dwell/blank timing.
    for (genvar gi = 0; gi < NI; gi++) begin : g_mon
        localparam logic [7:0] OFF_P = (P_AL[gi] != 0) ? 8'hFF : 8'h00;
        int since = 0;
        int lit = 0;
        always @(negedge clk) begin
            exp_t e;
            since++;
            if (bus[gi].row_start) begin
                if (exp_q[gi].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected_row_start: got idx %0d expected no visit", gi, bus[gi].idx);
                end else begin
                    e = exp_q[gi].pop_front();
                    cmp("visit_idx", gi, 32'(bus[gi].idx), 32'(e.idx));
                    cmp("visit_out", gi, 32'(bus[gi].out), 32'(e.out));
                    cmp("visit_frame_done", gi, 32'(bus[gi].frame_done), 32'(e.fd));
                    $display("dut%0d row visit idx=%0d out=%b fd=%0d gap=%0d lit=%0d",
                             gi, bus[gi].idx, bus[gi].out, bus[gi].frame_done, since, lit);
                    if (e.gap != 0) begin
                        cmp("row_period", gi, 32'(since), 32'(e.gap));
                        cmp("dwell_cycles", gi, 32'(lit), 32'(DW));
                    end
                end
                since = 0;
                lit = 0;
            end else if (bus[gi].frame_done) begin
                checks++;
                errors++;
                $display("FAIL dut%0d stray_frame_done: got 1 expected 0 without row_start", gi);
            end
            if (bus[gi].out != OFF_P) lit++;
        end
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            case (k)
                0: begin bus[0].ena = 0; bus[0].mode = 0; bus[0].sel = 0; end
                1: begin bus[1].ena = 0; bus[1].mode = 0; bus[1].sel = 0; end
                2: begin bus[2].ena = 0; bus[2].mode = 0; bus[2].sel = 0; end
                default: begin bus[3].ena = 0; bus[3].mode = 0; bus[3].sel = 0; end
            endcase
        end

        // Config 0: auto scan, wrap, ena drop mid-dwell, re-enable
        step(2);
        cmp("reset_out", 0, 32'(bus[0].out), 32'h00);
        cmp("reset_idx", 0, 32'(bus[0].idx), 32'd0);
        cmp("reset_row_start", 0, 32'(bus[0].row_start), 32'd0);
        cmp("reset_frame_done", 0, 32'(bus[0].frame_done), 32'd0);
        rst_n[0] = 1'b1;
        step(1);
        cmp("idle_out", 0, 32'(bus[0].out), 32'h00);
        push(0, 3'd0, 8'h01, 1'b0, 0);
        for (int r = 1; r < 8; r++) push(0, 3'(r), 8'(1 << r), 1'b0, 6);
        push(0, 3'd0, 8'h01, 1'b1, 6);
        push(0, 3'd1, 8'h02, 1'b0, 6);
        push(0, 3'd2, 8'h04, 1'b0, 6);
        push(0, 3'd3, 8'h08, 1'b0, 6);
        bus[0].ena = 1'b1;
        step(69);
        cmp("row3_dwell2_out", 0, 32'(bus[0].out), 32'h08);
        bus[0].ena = 1'b0;
        step(1);
        cmp("ena_drop_out", 0, 32'(bus[0].out), 32'h00);
        cmp("ena_drop_idx", 0, 32'(bus[0].idx), 32'd0);
        cmp("ena_drop_row_start", 0, 32'(bus[0].row_start), 32'd0);
        step(2);
        cmp("idle_hold_out", 0, 32'(bus[0].out), 32'h00);
        push(0, 3'd0, 8'h01, 1'b0, 0);
        push(0, 3'd1, 8'h02, 1'b0, 6);
        bus[0].ena = 1'b1;
        step(1);
        cmp("reenable_out", 0, 32'(bus[0].out), 32'h01);
        cmp("reenable_frame_done", 0, 32'(bus[0].frame_done), 32'd0);
        step(8);
        bus[0].ena = 1'b0;
        step(2);

        // Config 1: ROWS=6, switch to manual mid-row 2, then clamp sel=7 -> row 5
        rst_n[1] = 1'b1;
        push(1, 3'd0, 8'h01, 1'b0, 0);
        push(1, 3'd1, 8'h02, 1'b0, 6);
        push(1, 3'd2, 8'h04, 1'b0, 6);
        push(1, 3'd5, 8'h20, 1'b0, 6);
        push(1, 3'd5, 8'h20, 1'b0, 6);
        push(1, 3'd5, 8'h20, 1'b0, 6);
        bus[1].ena = 1'b1;
        step(14);
        bus[1].mode = 1'b1;
        bus[1].sel = 3'd5;
        step(3);
        cmp("mid_row_change_blank", 1, 32'(bus[1].out), 32'h00);
        cmp("mid_row_change_idx", 1, 32'(bus[1].idx), 32'd2);
        step(3);
        bus[1].sel = 3'd7;
        step(12);
        bus[1].ena = 1'b0;
        step(2);

        // Config 2: active-low polarity, reset mid-blank
        cmp("al_reset_out", 2, 32'(bus[2].out), 32'hFF);
        push(2, 3'd0, 8'hFE, 1'b0, 0);
        rst_n[2] = 1'b1;
        bus[2].ena = 1'b1;
        step(5);
        cmp("al_blank_out", 2, 32'(bus[2].out), 32'hFF);
        rst_n[2] = 1'b0;
        step(1);
        cmp("al_midblank_reset_out", 2, 32'(bus[2].out), 32'hFF);
        cmp("al_midblank_reset_idx", 2, 32'(bus[2].idx), 32'd0);
        cmp("al_midblank_reset_row_start", 2, 32'(bus[2].row_start), 32'd0);
        cmp("al_midblank_reset_frame_done", 2, 32'(bus[2].frame_done), 32'd0);
        push(2, 3'd0, 8'hFE, 1'b0, 0);
        push(2, 3'd1, 8'hFD, 1'b0, 6);
        rst_n[2] = 1'b1;
        step(1);
        cmp("al_release_out", 2, 32'(bus[2].out), 32'hFE);
        step(7);
        bus[2].ena = 1'b0;
        step(2);

        // Config 3: ROWS=1, BLANK=0: row 0 repeats, frame_done on each wrap
        rst_n[3] = 1'b1;
        push(3, 3'd0, 8'h01, 1'b0, 0);
        for (int r = 0; r < 4; r++) push(3, 3'd0, 8'h01, 1'b1, 4);
        bus[3].ena = 1'b1;
        step(17);
        cmp("single_row_out", 3, 32'(bus[3].out), 32'h01);
        bus[3].ena = 1'b0;
        step(3);

        for (int k = 0; k < NI; k++) cmp("pending_visits", k, 32'(exp_q[k].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_row_scanner.md
Name: decoder_row_scanner

Overview:
Parametrised, registered N-to-2^N one-hot decoder with a built-in row-scan sequencer, for driving Game of Life LED-matrix rows.
- Auto mode: steps through rows 0..ROWS-1. Each row is held for DWELL cycles, then blanked for BLANK cycles to suppress ghosting.
- Manual mode: holds the row selected by the sel input.
- Sits between the cell-state frame logic (consumes row_start/idx) and the row-driver pins.

Parameters:
N, 3, select width; decoded output width is 2**N.
ROWS, 8, rows actually scanned; 1 <= ROWS <= 2**N.
DWELL, 1000, cycles a row is driven per visit; >= 1.
BLANK, 4, all-off cycles between rows; 0 allowed (no blanking).
OUT_ACTIVE_LOW, 0, 1 inverts every bit of out (for PMOS row drivers).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
ena  in  1  scan enable; 0 forces idle/all-off.
mode  in  1  0 = auto scan, 1 = manual (row from sel).
sel  in  N  manual row index, sampled at row boundaries.
out  out  2**N  registered one-hot row drive (polarity per OUT_ACTIVE_LOW).
idx  out  N  index of current/next row.
row_start  out  1  one-cycle pulse on first driven cycle of each row visit.
frame_done  out  1  one-cycle pulse on the cycle idx wraps ROWS-1 -> 0 (auto mode only).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state S_IDLE, idx=0, dwell/blank counter=0.
  - row_start=0, frame_done=0.
  - out = all-off: 0, or all 1s when OUT_ACTIVE_LOW=1.
  - Reset wins over every other input, including mid-row.
- "Off" below means out = all-off in the active polarity.
- All outputs are registered. The decoded bit is out[idx] with no additional pipeline stage.
- S_IDLE:
  - out off.
  - On ena=1 at edge t: go to S_ACTIVE at t+1 with idx = (mode ? clamp(sel) : 0).
  - At t+1: out drives row idx and row_start=1.
- S_ACTIVE:
  - out = one-hot(idx) for exactly DWELL cycles; counter counts 0..DWELL-1.
  - On last dwell cycle: go to S_BLANK if BLANK>0; otherwise go directly to the next row.
- S_BLANK:
  - out off for exactly BLANK cycles.
  - Then go to S_ACTIVE with the next idx and row_start=1 on the first driven cycle.
- Next-row rule, evaluated at the row boundary:
  - auto: idx = (idx == ROWS-1) ? 0 : idx+1.
  - manual: idx = clamp(sel).
  - clamp(v) = (v >= ROWS) ? ROWS-1 : v.
- Row period is DWELL+BLANK cycles, constant.
- frame_done:
  - Pulses on the same cycle as row_start for row 0 when reached by wrap in auto mode.
  - Does not pulse on the initial entry from S_IDLE, nor in manual mode.
- mode or sel changes mid-row: no effect until the next row boundary. The current row completes dwell and blank unchanged.
- ena=0 in any state: S_IDLE next cycle, out off next cycle, idx=0, counter cleared. No pulses.
- Re-enable after idle restarts at row 0 (auto) or clamp(sel) (manual), with full DWELL.
- ROWS=1, auto: row 0 repeats every DWELL+BLANK cycles. row_start and frame_done both pulse on each repeat.
- Counter width: $clog2(max(DWELL, BLANK, 2)); no overflow permitted.
- Exactly one out bit is active in S_ACTIVE; none in S_IDLE or S_BLANK.

Decomposition:
- Package decoder_pkg:
  - typedef enum logic [1:0] scan_state_t {S_IDLE, S_ACTIVE, S_BLANK}.
  - function clamp_row.
- Sub-module decoder_n_to_onehot (params N; ports ena, in[N-1:0], out[2**N-1:0]):
  - Combinational parametrised generalisation of the existing fixed decoders.
  - The scanner registers its output and applies polarity.

Test Plan:
(Test config unless stated: N=3, ROWS=8, DWELL=4, BLANK=2, OUT_ACTIVE_LOW=0.)
- Reset then ena=1, mode=0 -> out=00000001 for 4 cycles, 00000000 for 2, then 00000010. row_start pulses every 6 cycles. idx steps 0..7.
- Run 48+ cycles auto -> after row 7 blank, out=00000001 with frame_done=1 and row_start=1 on the same cycle. No frame_done on the first entry.
- mode=1, sel=5 mid-row 2 -> row 2 completes 4+2 cycles, then out=00100000. Then sel=7 with ROWS=6 -> out=00100000 (clamped to row 5).
- ena dropped on dwell cycle 2 of row 3 -> out=00000000 next cycle, idx=0. Re-assert -> out=00000001 after 1 cycle with full 4-cycle dwell.
- rst_n=0 mid-blank with OUT_ACTIVE_LOW=1 -> out=11111111 next cycle, pulses 0. After release with ena=1, out=11111110.
- BLANK=0, ROWS=1 -> out constantly 00000001. row_start and frame_done pulse every 4 cycles.
